// File: rtl/aes_stream_packer_pkg.sv
// Shared state encoding, sizes and word-select helper for the AES
// input-bus stream packer.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_KEY_LO,
        ST_KEY_HI,
        ST_IV,
        ST_DATA
    } state_t;

    localparam int WORDS_PER_BLK   = 4;
    localparam int BLK_BITS        = 128;
    localparam int AES128_KEY_BITS = 128;
    localparam int AES256_KEY_BITS = 256;

    // Most-significant word first: idx 0 selects bits [127:96].
    function automatic logic [31:0] blk_word(
        input logic [BLK_BITS-1:0] blk,
        input logic [1:0]          idx
    );
        logic [31:0] w;
        w = blk[31:0];
        unique case (idx)
            2'd0: w = blk[127:96];
            2'd1: w = blk[95:64];
            2'd2: w = blk[63:32];
            2'd3: w = blk[31:0];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_stream_packer_if.sv
// Upstream block handshake plus controller-side word bus of the
// stream packer.
interface aes_stream_packer_if
    import aes_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 32
);
    logic                      blk_tvalid;
    logic                      blk_tready;
    logic [BLK_BITS-1:0]       blk_tdata;
    logic                      bus_data_wren;
    logic                      bus_tlast;
    logic [BUS_DATA_WIDTH-1:0] bus_data;
    logic                      controller_in_busy;

    modport master (
        input  blk_tvalid,
        input  blk_tdata,
        input  controller_in_busy,
        output blk_tready,
        output bus_data_wren,
        output bus_tlast,
        output bus_data
    );

    modport slave (
        output blk_tvalid,
        output blk_tdata,
        output controller_in_busy,
        input  blk_tready,
        input  bus_data_wren,
        input  bus_tlast,
        input  bus_data
    );
endinterface

// File: rtl/aes_stream_packer_word_serializer.sv
// 128-bit holding register emitted as four 32-bit words, MS word first;
// shared by the key, IV and data fields.
module aes_word_serializer
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [BLK_BITS-1:0] i_data,
    input  logic                i_adv,
    output logic [31:0]         o_word,
    output logic                o_last
);

    logic [BLK_BITS-1:0] r_data;
    logic [1:0]          r_idx;

    // A load restarts the index and wins over a concurrent advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_data <= i_data;
            r_idx  <= '0;
        end else if (i_adv) begin
            r_idx  <= r_idx + 2'd1;
        end
    end

    assign o_word = blk_word(r_data, r_idx);
    assign o_last = (r_idx == 2'(WORDS_PER_BLK - 1));

endmodule

// File: rtl/aes_stream_packer.sv
// Frames command, key, optional IV and data blocks into one 32-bit word
// stream for the AES controller input bus.
module aes_stream_packer
    import aes_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 32,
    parameter int CNT_WIDTH      = 16
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [BUS_DATA_WIDTH-1:0]  cmd,
    input  logic [AES256_KEY_BITS-1:0] key,
    input  logic                       key_256,
    input  logic [BLK_BITS-1:0]        iv,
    input  logic                       need_iv,
    input  logic [CNT_WIDTH-1:0]       blk_count,
    output logic                       busy,
    output logic                       done,
    aes_stream_packer_if.master        bus
);

    state_t r_state;
    state_t w_next;

    logic [BUS_DATA_WIDTH-1:0]  r_cmd;
    logic [AES256_KEY_BITS-1:0] r_key;
    logic                       r_key256;
    logic [BLK_BITS-1:0]        r_iv;
    logic                       r_need_iv;
    logic [CNT_WIDTH-1:0]       r_cnt;
    logic                       r_full;
    logic                       r_done;

    logic                w_start;
    logic                w_more;
    logic                w_avail;
    logic                w_wren;
    logic                w_to_data;
    logic                w_field_end;
    logic                w_tready;
    logic                w_blk_load;
    logic                w_tlast;
    logic                w_ser_load;
    logic [BLK_BITS-1:0] w_ser_data;
    logic [31:0]         w_ser_word;
    logic                w_ser_last;

    assign w_start = (r_state == ST_IDLE) && start && !r_done;
    assign w_more  = (r_cnt != '0);

    aes_word_serializer u_ser (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_ser_load),
        .i_data (w_ser_data),
        .i_adv  (w_wren),
        .o_word (w_ser_word),
        .o_last (w_ser_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) w_next = ST_CMD;
            end
            ST_CMD: begin
                if (w_wren) w_next = ST_KEY_LO;
            end
            ST_KEY_LO: begin
                if (w_field_end) begin
                    if (r_key256)       w_next = ST_KEY_HI;
                    else if (r_need_iv) w_next = ST_IV;
                    else if (w_more)    w_next = ST_DATA;
                    else                w_next = ST_IDLE;
                end
            end
            ST_KEY_HI: begin
                if (w_field_end) begin
                    if (r_need_iv)   w_next = ST_IV;
                    else if (w_more) w_next = ST_DATA;
                    else             w_next = ST_IDLE;
                end
            end
            ST_IV: begin
                if (w_field_end) begin
                    w_next = w_more ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_field_end && !w_more) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // w_to_data marks the field whose last word precedes the data blocks.
    always_comb begin
        w_avail    = 1'b0;
        w_to_data  = 1'b0;
        w_ser_load = 1'b0;
        w_ser_data = r_key[AES128_KEY_BITS-1:0];
        unique case (r_state)
            ST_CMD:    w_avail = 1'b1;
            ST_KEY_LO: begin
                w_avail   = 1'b1;
                w_to_data = !r_key256 && !r_need_iv;
            end
            ST_KEY_HI: begin
                w_avail   = 1'b1;
                w_to_data = !r_need_iv;
            end
            ST_IV: begin
                w_avail   = 1'b1;
                w_to_data = 1'b1;
            end
            ST_DATA: begin
                w_avail   = r_full;
                w_to_data = 1'b1;
            end
            default: ;
        endcase

        w_wren      = w_avail && !bus.controller_in_busy;
        w_field_end = w_wren && w_ser_last && (r_state != ST_CMD);
        w_tready    = w_more &&
                      (((r_state == ST_DATA) && !r_full) ||
                       (w_field_end && w_to_data));
        w_blk_load  = w_tready && bus.blk_tvalid;
        w_tlast     = w_field_end && w_to_data && !w_more;

        if (w_blk_load) begin
            w_ser_load = 1'b1;
            w_ser_data = bus.blk_tdata;
        end else if ((r_state == ST_CMD) && w_wren) begin
            w_ser_load = 1'b1;
            w_ser_data = r_key[AES128_KEY_BITS-1:0];
        end else if (w_field_end && (r_state == ST_KEY_LO) && r_key256) begin
            w_ser_load = 1'b1;
            w_ser_data = r_key[AES256_KEY_BITS-1:AES128_KEY_BITS];
        end else if (w_field_end && !w_to_data) begin
            w_ser_load = 1'b1;
            w_ser_data = r_iv;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd     <= '0;
            r_key     <= '0;
            r_key256  <= 1'b0;
            r_iv      <= '0;
            r_need_iv <= 1'b0;
            r_cnt     <= '0;
            r_full    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_tlast;
            if (w_start) begin
                r_cmd     <= cmd;
                r_key     <= key;
                r_key256  <= key_256;
                r_iv      <= iv;
                r_need_iv <= need_iv;
                r_cnt     <= blk_count;
            end else if (w_blk_load) begin
                r_cnt <= r_cnt - CNT_WIDTH'(1);
            end
            if (w_blk_load) begin
                r_full <= 1'b1;
            end else if ((r_state == ST_DATA) && w_field_end) begin
                r_full <= 1'b0;
            end
        end
    end

    assign bus.bus_data_wren = w_wren;
    assign bus.bus_tlast     = w_tlast;
    assign bus.blk_tready    = w_tready;
    assign bus.bus_data      = !w_avail ? '0 :
                               (r_state == ST_CMD) ? r_cmd : w_ser_word;
    assign busy              = (r_state != ST_IDLE);
    assign done              = r_done;

endmodule

// File: tb/tb_aes_stream_packer.sv
// Directed self-checking bench for aes_stream_packer.
`timescale 1ns/1ps
module tb_aes_stream_packer;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [31:0]  cmd = '0;
    logic [255:0] key = '0;
    logic         key_256 = 1'b0;
    logic [127:0] iv = '0;
    logic         need_iv = 1'b0;
    logic [15:0]  blk_count = '0;
    logic         busy;
    logic         done;

    aes_stream_packer_if bus();

    aes_stream_packer #(
        .BUS_DATA_WIDTH (32),
        .CNT_WIDTH      (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cmd       (cmd),
        .key       (key),
        .key_256   (key_256),
        .iv        (iv),
        .need_iv   (need_iv),
        .blk_count (blk_count),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int up_idx = 0;
    logic [127:0] blocks [16];

    logic [31:0] cap_data [$];
    bit          cap_last [$];
    int          cap_cyc  [$];
    int          n_tready = 0;
    int          n_busy_wren = 0;
    int          n_bad_tlast = 0;
    int          n_done = 0;
    int          last_done_cyc = 0;
    logic        done_busy = 1'b0;
    logic [31:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (bus.blk_tvalid && bus.blk_tready) up_idx <= up_idx + 1;

    assign bus.blk_tdata = blocks[up_idx[3:0]];

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.bus_data_wren) begin
                cap_data.push_back(bus.bus_data);
                cap_last.push_back(bus.bus_tlast);
                cap_cyc.push_back(cyc);
            end
            if (bus.bus_tlast && !bus.bus_data_wren) n_bad_tlast++;
            if (bus.blk_tready) n_tready++;
            if (bus.controller_in_busy && bus.bus_data_wren) n_busy_wren++;
            if (done) begin
                n_done++;
                last_done_cyc = cyc;
                done_busy = busy;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_field(input logic [127:0] f);
        exp_q.push_back(f[127:96]);
        exp_q.push_back(f[95:64]);
        exp_q.push_back(f[63:32]);
        exp_q.push_back(f[31:0]);
    endtask

    task automatic build_exp(input int n, input int first);
        exp_q = {};
        exp_q.push_back(cmd);
        push_field(key[127:0]);
        if (key_256) push_field(key[255:128]);
        if (need_iv) push_field(iv);
        for (int b = 0; b < n; b++) push_field(blocks[(first + b) % 16]);
    endtask

    task automatic do_start(output int s);
        @(posedge clk); #1;
        s = cyc + 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int i = 0;
        while (n_done == d0 && i < 300) begin
            @(posedge clk); #1;
            i++;
        end
        chk({tag, "_timeout"}, 64'(n_done != d0), 1);
        repeat (2) begin @(posedge clk); #1; end
        chk({tag, "_done_pulses"}, n_done - d0, 1);
        chk({tag, "_done_busy"}, done_busy, 0);
    endtask

    task automatic check_frame(input string tag, input int base,
                               input int s, input int span);
        int n;
        n = cap_data.size() - base;
        chk({tag, "_nwords"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i), cap_data[base + i], exp_q[i]);
            chk($sformatf("%s_tl%0d", tag, i), cap_last[base + i],
                64'(i == exp_q.size() - 1));
        end
        if (n > 0) begin
            chk({tag, "_first_cyc"}, cap_cyc[base], s);
            chk({tag, "_span"}, cap_cyc[base + n - 1] - s + 1, span);
            chk({tag, "_done_cyc"}, last_done_cyc, cap_cyc[base + n - 1] + 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int base;
        int d0;
        int t0;

        for (int i = 0; i < 16; i++)
            blocks[i] = {32'hD000_0000 + 32'(i * 16), 32'hD000_0001 + 32'(i * 16),
                         32'hD000_0002 + 32'(i * 16), 32'hD000_0003 + 32'(i * 16)};
        blocks[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        bus.blk_tvalid = 1'b0;
        bus.controller_in_busy = 1'b0;

        repeat (2) begin @(posedge clk); #1; end
        chk("rst_wren", bus.bus_data_wren, 0);
        chk("rst_tlast", bus.bus_tlast, 0);
        chk("rst_data", bus.bus_data, 0);
        chk("rst_tready", bus.blk_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        // 128-bit key, no IV, one block: hand-listed words
        cmd = 32'hC0DE0001;
        key = {128'h0, 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C};
        key_256 = 1'b0;
        need_iv = 1'b0;
        blk_count = 16'd1;
        bus.blk_tvalid = 1'b1;
        exp_q = {32'hC0DE0001, 32'h2B7E1516, 32'h28AED2A6, 32'hABF71588,
                 32'h09CF4F3C, 32'h00112233, 32'h44556677, 32'h8899AABB,
                 32'hCCDDEEFF};
        base = cap_data.size();
        d0 = n_done;
        do_start(s);
        chk("t1_busy", busy, 1);
        wait_done("t1", d0);
        check_frame("t1", base, s, 9);

        // 256-bit key, IV, two back-to-back blocks
        cmd = 32'hC0DE0002;
        key = {128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4,
               128'h11121314_21222324_31323334_41424344};
        key_256 = 1'b1;
        iv = 128'hF0F1F2F3_E0E1E2E3_D0D1D2D3_C0C1C2C3;
        need_iv = 1'b1;
        blk_count = 16'd2;
        build_exp(2, up_idx);
        base = cap_data.size();
        d0 = n_done;
        do_start(s);
        wait_done("t2", d0);
        check_frame("t2", base, s, 21);

        // controller back-pressure for 3 cycles during the key
        cmd = 32'hC0DE0003;
        key_256 = 1'b0;
        need_iv = 1'b0;
        blk_count = 16'd1;
        build_exp(1, up_idx);
        base = cap_data.size();
        d0 = n_done;
        t0 = n_busy_wren;
        do_start(s);
        repeat (2) begin @(posedge clk); #1; end
        bus.controller_in_busy = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.controller_in_busy = 1'b0;
        wait_done("t3", d0);
        check_frame("t3", base, s, 12);
        chk("t3_busy_wren", n_busy_wren - t0, 0);

        // upstream valid gap of 5 cycles between two blocks
        cmd = 32'hC0DE0004;
        blk_count = 16'd2;
        build_exp(2, up_idx);
        base = cap_data.size();
        d0 = n_done;
        do_start(s);
        repeat (5) begin @(posedge clk); #1; end
        bus.blk_tvalid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        bus.blk_tvalid = 1'b1;
        wait_done("t4", d0);
        check_frame("t4", base, s, 15);

        // zero blocks with IV: header only, no block request
        cmd = 32'hC0DE0005;
        need_iv = 1'b1;
        iv = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        blk_count = 16'd0;
        build_exp(0, up_idx);
        base = cap_data.size();
        d0 = n_done;
        t0 = n_tready;
        do_start(s);
        wait_done("t5", d0);
        check_frame("t5", base, s, 9);
        chk("t5_tready", n_tready - t0, 0);

        // asynchronous reset in the middle of DATA
        cmd = 32'hC0DE0006;
        need_iv = 1'b0;
        blk_count = 16'd3;
        do_start(s);
        repeat (7) begin @(posedge clk); #1; end
        chk("t6_pre_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_wren", bus.bus_data_wren, 0);
        chk("t6_rst_data", bus.bus_data, 0);
        chk("t6_rst_tready", bus.blk_tready, 0);
        chk("t6_rst_tlast", bus.bus_tlast, 0);
        chk("t6_rst_busy", busy, 0);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("t6_idle_busy", busy, 0);

        cmd = 32'hC0DE0007;
        need_iv = 1'b1;
        blk_count = 16'd2;
        build_exp(2, up_idx);
        base = cap_data.size();
        d0 = n_done;
        do_start(s);
        wait_done("t7", d0);
        check_frame("t7", base, s, 17);
        chk("stray_tlast", n_bad_tlast, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
